// File: rtl/oclib_pkg.sv
// oclib_pkg: shared types and constants for the oclib CSR / byte-channel blocks.
//   bc_8b_bidi_s : one direction of an 8-bit byte channel plus the backpressure
//                  (ready) for the opposite direction.
//   csr_32_s     : CSR request (read, write, address, wdata), 66 bits.
//   csr_32_fb_s  : CSR feedback (rdata, ready, error), 34 bits.
package oclib_pkg;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       ready;
  } bc_8b_bidi_s;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] wdata;
  } csr_32_s;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
    logic        error;
  } csr_32_fb_s;

  // Default response timeout for the CSR-to-BC bridge, in clock cycles.
  localparam int          CsrToBcTimeoutDefault = 1024;
  // Read data reported when a remote never answers.
  localparam logic [31:0] CsrTimeoutRdata       = 32'hDEAD_DEAD;

endpackage

// File: rtl/oclib_words_to_bc_bidi.sv
// oclib_words_to_bc_bidi: generic word <-> byte-channel converter.
//   Serializer  : takes one WordOutWidth-bit word (wordOutValid/wordOutReady),
//                 sends it LSB byte first on bcOut, zero-padding the last byte.
//                 wordOutDone pulses on the cycle the final byte transfers.
//   Deserializer: while wordInReady is high, collects LSB-first bytes from bcIn;
//                 wordInValid pulses (combinationally) on the cycle the final
//                 byte transfers, with wordIn holding the assembled word.
//                 Bytes arriving while wordInReady is low are accepted and dropped.
//   bcReadyNext : next-cycle value of bcOut.ready (our acceptance of bcIn bytes).
// Ports: clock, reset (async, active-high), wordOut*, wordIn*, bcReadyNext,
//        bcOut, bcIn.
module oclib_words_to_bc_bidi
  import oclib_pkg::*;
#(
  parameter type BcType       = oclib_pkg::bc_8b_bidi_s,
  parameter int  WordOutWidth = 66,
  parameter int  WordInWidth  = 34
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [WordOutWidth-1:0] wordOut,
  input  logic                    wordOutValid,
  output logic                    wordOutReady,
  output logic                    wordOutDone,
  output logic [WordInWidth-1:0]  wordIn,
  output logic                    wordInValid,
  input  logic                    wordInReady,
  input  logic                    bcReadyNext,
  output BcType                   bcOut,
  input  BcType                   bcIn
);

  localparam int OutBytes = (WordOutWidth + 7) / 8;
  localparam int InBytes  = (WordInWidth + 7) / 8;
  localparam int OutPadW  = OutBytes * 8;
  localparam int InPadW   = InBytes * 8;
  localparam int OutCntW  = (OutBytes > 1) ? $clog2(OutBytes) : 1;
  localparam int InCntW   = (InBytes > 1) ? $clog2(InBytes) : 1;

  logic [OutPadW-1:0] txPadded_s;
  logic [OutPadW-9:0] txShift_r;     // bytes still to send after the current one
  logic [OutCntW-1:0] txCnt_r;
  logic [7:0]         txData_r;
  logic               txValid_r;
  logic               txXfer_s;
  logic               txLast_s;

  logic [InPadW-9:0]  rxShift_r;     // bytes received so far, newest at the top
  logic [InCntW-1:0]  rxCnt_r;
  logic               rxReady_r;
  logic               rxXfer_s;
  logic               rxLast_s;
  logic [InPadW-1:0]  rxAssembled_s;
  logic               unused_s;

  assign txPadded_s   = OutPadW'(wordOut);
  assign txXfer_s     = txValid_r && bcIn.ready;
  assign txLast_s     = (txCnt_r == OutCntW'(OutBytes - 1));
  assign wordOutReady = !txValid_r;
  assign wordOutDone  = txXfer_s && txLast_s;

  // Serializer: load a word, then shift one byte out per accepted transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      txShift_r <= '0;
      txCnt_r   <= '0;
      txData_r  <= 8'h00;
      txValid_r <= 1'b0;
    end else if (txValid_r) begin
      if (bcIn.ready) begin
        if (txLast_s) begin
          txCnt_r   <= '0;
          txData_r  <= 8'h00;
          txValid_r <= 1'b0;
        end else begin
          txCnt_r   <= txCnt_r + OutCntW'(1);
          txData_r  <= txShift_r[7:0];
          txShift_r <= txShift_r >> 8;
        end
      end else begin
        txCnt_r <= txCnt_r;          // stalled: data and valid hold
      end
    end else if (wordOutValid) begin
      txShift_r <= txPadded_s[OutPadW-1:8];
      txData_r  <= txPadded_s[7:0];
      txCnt_r   <= '0;
      txValid_r <= 1'b1;
    end else begin
      txValid_r <= 1'b0;
    end
  end

  assign rxXfer_s      = bcIn.valid && rxReady_r;
  assign rxLast_s      = (rxCnt_r == InCntW'(InBytes - 1));
  assign rxAssembled_s = {bcIn.data, rxShift_r};
  assign wordIn        = rxAssembled_s[WordInWidth-1:0];
  assign wordInValid   = rxXfer_s && wordInReady && rxLast_s;

  // Deserializer: collect bytes only while the consumer is waiting for a word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxShift_r <= '0;
      rxCnt_r   <= '0;
      rxReady_r <= 1'b1;
    end else begin
      rxReady_r <= bcReadyNext;
      if (!wordInReady) begin
        rxCnt_r <= '0;               // discard anything outside a response window
      end else if (rxXfer_s) begin
        rxShift_r <= rxAssembled_s[InPadW-1:8];
        rxCnt_r   <= rxLast_s ? '0 : (rxCnt_r + InCntW'(1));
      end else begin
        rxCnt_r <= rxCnt_r;
      end
    end
  end

  assign bcOut.data  = txData_r;
  assign bcOut.valid = txValid_r;
  assign bcOut.ready = rxReady_r;

  // Pad bits of the received word carry no information.
  assign unused_s = ^rxAssembled_s;

endmodule

// File: rtl/oclib_csr_to_bc.sv
// oclib_csr_to_bc: CSR initiator-side bridge onto an 8-bit bidirectional byte
// channel. One request from the local master is serialized (LSB byte first,
// 9 bytes), the 5-byte response is collected and reported on csrFb with a
// single-cycle ready pulse. A Hold state waits for the master to drop
// read/write so a held request is never reissued. read&&write together is
// rejected locally with error=1 and nothing is sent.
// Ports: clock; reset (async, active-high); csr (request in); csrFb (feedback
//        out); bcOut (request bytes out, ready = our acceptance of bcIn);
//        bcIn (response bytes in, ready = remote acceptance of bcOut).
// Optional build macro OC_CSR_TO_BC_TIMEOUT_EN: abort WaitResp after
// TimeoutCycles idle cycles with error=1, rdata=32'hDEAD_DEAD.
module oclib_csr_to_bc
  import oclib_pkg::*;
#(
  parameter type BcType        = oclib_pkg::bc_8b_bidi_s,
  parameter type CsrType       = oclib_pkg::csr_32_s,
  parameter type CsrFbType     = oclib_pkg::csr_32_fb_s,
  parameter int  TimeoutCycles = CsrToBcTimeoutDefault
) (
  input  logic     clock,
  input  logic     reset,
  input  CsrType   csr,
  output CsrFbType csrFb,
  output BcType    bcOut,
  input  BcType    bcIn
);

  localparam int CsrWidth   = $bits(CsrType);
  localparam int CsrFbWidth = $bits(CsrFbType);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StSendReq  = 3'd1;
  localparam logic [2:0] StWaitResp = 3'd2;
  localparam logic [2:0] StAck      = 3'd3;
  localparam logic [2:0] StHold     = 3'd4;

  logic [2:0]            state_r;
  logic [2:0]            stateNext_s;
  CsrFbType              csrFb_r;
  CsrFbType              fbNext_s;
  CsrFbType              respFb_s;
  logic                  wordOutValid_s;
  logic                  wordOutReady_s;
  logic                  wordOutDone_s;
  logic [CsrFbWidth-1:0] wordIn_s;
  logic                  wordInValid_s;
  logic                  wordInReady_s;
  logic                  bcReadyNext_s;
  logic                  timeout_s;
  logic                  unused_s;

  assign respFb_s = CsrFbType'(wordIn_s);

  // Next-state and next-feedback decode for the CSR transaction FSM.
  always_comb begin
    stateNext_s    = state_r;
    fbNext_s       = csrFb_r;
    fbNext_s.ready = 1'b0;
    wordOutValid_s = 1'b0;
    wordInReady_s  = 1'b0;
    case (state_r)
      StIdle: begin
        if (csr.read ^ csr.write) begin
          wordOutValid_s = 1'b1;
          if (wordOutReady_s) begin
            stateNext_s = StSendReq;
          end else begin
            stateNext_s = StIdle;
          end
        end else if (csr.read && csr.write) begin
          // Ambiguous request: answer locally, never touch the channel.
          stateNext_s    = StAck;
          fbNext_s.ready = 1'b1;
          fbNext_s.error = 1'b1;
          fbNext_s.rdata = 32'h0000_0000;
        end else begin
          stateNext_s = StIdle;
        end
      end
      StSendReq: begin
        if (wordOutDone_s) begin
          stateNext_s = StWaitResp;
        end else begin
          stateNext_s = StSendReq;
        end
      end
      StWaitResp: begin
        wordInReady_s = 1'b1;
        if (wordInValid_s) begin
          stateNext_s    = StAck;
          fbNext_s.ready = 1'b1;
          fbNext_s.rdata = respFb_s.rdata;
          fbNext_s.error = respFb_s.error;
        end else if (timeout_s) begin
          stateNext_s    = StAck;
          fbNext_s.ready = 1'b1;
          fbNext_s.rdata = CsrTimeoutRdata;
          fbNext_s.error = 1'b1;
        end else begin
          stateNext_s = StWaitResp;
        end
      end
      StAck: begin
        stateNext_s = StHold;
      end
      StHold: begin
        if (!csr.read && !csr.write) begin
          stateNext_s = StIdle;
        end else begin
          stateNext_s = StHold;
        end
      end
      default: begin
        stateNext_s = StIdle;
      end
    endcase
    // Response bytes are refused only while the feedback pulse is out.
    bcReadyNext_s = (stateNext_s != StAck);
  end

  // FSM state and registered CSR feedback.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= StIdle;
      csrFb_r <= '0;
    end else begin
      state_r <= stateNext_s;
      csrFb_r <= fbNext_s;
    end
  end

`ifdef OC_CSR_TO_BC_TIMEOUT_EN
  logic [31:0] timer_r;
  logic        byteInXfer_s;

  assign byteInXfer_s = bcIn.valid && bcOut.ready;
  assign timeout_s    = !byteInXfer_s && (timer_r == 32'(TimeoutCycles - 1));

  // Response timer: zero outside WaitResp, counts idle WaitResp cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_r <= 32'h0000_0000;
    end else if (state_r != StWaitResp) begin
      timer_r <= 32'h0000_0000;
    end else if (!byteInXfer_s) begin
      timer_r <= timer_r + 32'h0000_0001;
    end else begin
      timer_r <= timer_r;
    end
  end
`else
  // No timeout hardware: always false; TimeoutCycles kept for a common interface.
  assign timeout_s = (TimeoutCycles < 0);
`endif

  oclib_words_to_bc_bidi #(
    .BcType      (BcType),
    .WordOutWidth(CsrWidth),
    .WordInWidth (CsrFbWidth)
  ) uWords (
    .clock       (clock),
    .reset       (reset),
    .wordOut     (csr),
    .wordOutValid(wordOutValid_s),
    .wordOutReady(wordOutReady_s),
    .wordOutDone (wordOutDone_s),
    .wordIn      (wordIn_s),
    .wordInValid (wordInValid_s),
    .wordInReady (wordInReady_s),
    .bcReadyNext (bcReadyNext_s),
    .bcOut       (bcOut),
    .bcIn        (bcIn)
  );

  assign csrFb = csrFb_r;

  // The remote's own ready bit inside the response frame is not meaningful here.
  assign unused_s = respFb_s.ready;

endmodule

// File: tb/tb_oclib_csr_to_bc.sv
module tb_oclib_csr_to_bc;
  import oclib_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  csr_32_s     csr;
  csr_32_fb_s  csrFb;
  bc_8b_bidi_s bcOut;
  bc_8b_bidi_s bcIn;

  always #5 clock = ~clock;

  oclib_csr_to_bc #(.TimeoutCycles(16)) dut (
    .clock(clock), .reset(reset), .csr(csr), .csrFb(csrFb), .bcOut(bcOut), .bcIn(bcIn)
  );

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] respRdata;
    logic        respErr;
    bit          stall;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  logic [7:0]  reqByteQ[$];
  logic [7:0]  respByteQ[$];
  logic [32:0] fbExpQ[$];
  bit   stallMode = 0, respArmed = 0, inXferPend = 0, stallPending = 0;
  logic [7:0] stallData;
  int reqSeen = 0, outBytes = 0, pulses = 0;
  int lastInCycle = 0, pulseCycle = 0, frameDoneCycle = 0;
  vec_t vecs[5];
  vec_t postReset;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: remote drives after the edge, monitor samples at the falling edge.
  task automatic step();
    logic [7:0]  b;
    logic [32:0] f;
    @(posedge clock);
    #1;
    if (inXferPend) begin
      void'(respByteQ.pop_front());
      inXferPend = 0;
    end
    if (respByteQ.size() == 0) respArmed = 0;
    bcIn.valid = respArmed;
    bcIn.data  = respArmed ? respByteQ[0] : 8'h00;
    bcIn.ready = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clock);
    cycle++;
    if (stallPending) begin
      check("stall_valid", 64'(bcOut.valid), 64'd1);
      check("stall_data", 64'(bcOut.data), 64'(stallData));
    end
    stallPending = bcOut.valid && !bcIn.ready;
    stallData    = bcOut.data;
    if (bcOut.valid && bcIn.ready) begin
      outBytes++;
      if (reqByteQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req_byte actual=%0h required=none", bcOut.data);
      end else begin
        b = reqByteQ.pop_front();
        check("req_byte", 64'(bcOut.data), 64'(b));
      end
      reqSeen++;
      if (reqSeen == 9) begin
        reqSeen = 0;
        respArmed = 1;
        frameDoneCycle = cycle;
      end
    end
    if (bcIn.valid && bcOut.ready) begin
      inXferPend = 1;
      lastInCycle = cycle;
    end
    if (csrFb.ready) begin
      pulses++;
      pulseCycle = cycle;
      if (fbExpQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fb_pulse actual=%0h required=none", csrFb);
      end else begin
        f = fbExpQ.pop_front();
        check("fb_rdata", 64'(csrFb.rdata), 64'(f[31:0]));
        check("fb_error", 64'(csrFb.error), 64'(f[32]));
      end
    end
  endtask

  task automatic pushFrame(input csr_32_s c);
    logic [71:0] w;
    w = 72'(c);
    for (int i = 0; i < 9; i++) reqByteQ.push_back(w[8*i +: 8]);
  endtask

  task automatic pushResp(input logic [31:0] rdata, input logic err);
    logic [39:0] r;
    r = 40'({rdata, 1'b1, err});
    for (int i = 0; i < 5; i++) respByteQ.push_back(r[8*i +: 8]);
  endtask

  task automatic waitPulse(input string name, input int p0, input int budget);
    for (int n = 0; n < budget && pulses == p0; n++) step();
    check({name, "_pulse"}, 64'(pulses), 64'(p0 + 1));
  endtask

  task automatic runTxn(input vec_t v);
    int p0;
    p0 = pulses;
    csr.read = v.rd;
    csr.write = v.wr;
    csr.address = v.addr;
    csr.wdata = v.wdata;
    if (v.rd ^ v.wr) begin
      pushFrame(csr);
      pushResp(v.respRdata, v.respErr);
    end
    fbExpQ.push_back({v.expErr, v.expRdata});
    stallMode = v.stall;
    step();
    if (v.rd ^ v.wr) begin
      check({v.name, "_first_valid"}, 64'(bcOut.valid), 64'd1);
    end else begin
      check({v.name, "_err_ready"}, 64'(csrFb.ready), 64'd1);
      check({v.name, "_no_bytes"}, 64'(bcOut.valid), 64'd0);
    end
    waitPulse(v.name, p0, 400);
    if (v.rd ^ v.wr) check({v.name, "_resp_latency"}, 64'(pulseCycle - lastInCycle), 64'd1);
    csr = '0;
    stallMode = 0;
    repeat (3) step();
    check({v.name, "_one_pulse"}, 64'(pulses), 64'(p0 + 1));
    check({v.name, "_req_drained"}, 64'(reqByteQ.size()), 64'd0);
    check({v.name, "_resp_drained"}, 64'(respByteQ.size()), 64'd0);
  endtask

  initial begin
    int p0, ob0;
    vecs[0] = '{"wr_basic", 1'b0, 1'b1, 32'h0000_0010, 32'hA5A5_1234, 32'h0000_0000, 1'b0, 0, 32'h0000_0000, 1'b0};
    vecs[1] = '{"rd_stall", 1'b1, 1'b0, 32'h0000_0044, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 1, 32'hCAFE_F00D, 1'b0};
    vecs[2] = '{"rd_and_wr", 1'b1, 1'b1, 32'h0000_0050, 32'h1111_2222, 32'h0000_0000, 1'b0, 0, 32'h0000_0000, 1'b1};
    vecs[3] = '{"rd_err", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h1234_5678, 1'b1, 1, 32'h1234_5678, 1'b1};
    vecs[4] = '{"wr_ones", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 0, 32'h0000_0000, 1'b0};
    postReset = '{"rd_post_rst", 1'b1, 1'b0, 32'h0000_0060, 32'h0000_0000, 32'h5A5A_0F0F, 1'b0, 0, 32'h5A5A_0F0F, 1'b0};

    reset = 1'b1;
    csr = '0;
    bcIn = '{data: 8'h00, valid: 1'b0, ready: 1'b1};
    step();
    step();
    check("rst_csrFb", 64'(csrFb), 64'd0);
    check("rst_bc_valid", 64'(bcOut.valid), 64'd0);
    check("rst_bc_data", 64'(bcOut.data), 64'd0);
    check("rst_bc_ready", 64'(bcOut.ready), 64'd1);
    reset = 1'b0;
    step();

    for (int i = 0; i < 5; i++) runTxn(vecs[i]);

    // Held read: exactly one frame until the master drops the request.
    p0 = pulses;
    csr = '0;
    csr.read = 1'b1;
    csr.address = 32'h0000_0020;
    pushFrame(csr);
    pushResp(32'h0BAD_F00D, 1'b0);
    fbExpQ.push_back({1'b0, 32'h0BAD_F00D});
    waitPulse("hold_first", p0, 400);
    ob0 = outBytes;
    repeat (20) step();
    check("hold_no_reissue_bytes", 64'(outBytes), 64'(ob0));
    check("hold_no_reissue_pulse", 64'(pulses), 64'(p0 + 1));
    csr.read = 1'b0;
    step();
    csr.read = 1'b1;
    csr.address = 32'h0000_0024;
    pushFrame(csr);
    pushResp(32'h7777_8888, 1'b0);
    fbExpQ.push_back({1'b0, 32'h7777_8888});
    waitPulse("hold_second", p0 + 1, 400);
    check("hold_second_frame", 64'(outBytes), 64'(ob0 + 9));
    csr = '0;
    repeat (3) step();

    // Reset in the middle of a request frame.
    p0 = pulses;
    ob0 = outBytes;
    csr.write = 1'b1;
    csr.address = 32'h0000_0030;
    csr.wdata = 32'h1122_3344;
    pushFrame(csr);
    for (int n = 0; n < 50 && outBytes < ob0 + 4; n++) step();
    check("mid_rst_bytes_sent", 64'(outBytes), 64'(ob0 + 4));
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_bc_valid", 64'(bcOut.valid), 64'd0);
    check("mid_rst_bc_data", 64'(bcOut.data), 64'd0);
    check("mid_rst_bc_ready", 64'(bcOut.ready), 64'd1);
    check("mid_rst_csrFb", 64'(csrFb), 64'd0);
    reqByteQ.delete();
    csr = '0;
    stallPending = 0;
    reqSeen = 0;
    inXferPend = 0;
    respArmed = 0;
    step();
    step();
    reset = 1'b0;
    ob0 = outBytes;
    respByteQ.push_back(8'h3C);
    respByteQ.push_back(8'hC3);
    respByteQ.push_back(8'hFF);
    respArmed = 1;
    for (int n = 0; n < 20 && respByteQ.size() != 0; n++) step();
    step();
    check("stray_drained", 64'(respByteQ.size()), 64'd0);
    check("stray_no_pulse", 64'(pulses), 64'(p0));
    check("stray_no_bytes", 64'(outBytes), 64'(ob0));
    runTxn(postReset);

    // No response from the remote.
    p0 = pulses;
    csr = '0;
    csr.read = 1'b1;
    csr.address = 32'h0000_0040;
    pushFrame(csr);
`ifdef OC_CSR_TO_BC_TIMEOUT_EN
    fbExpQ.push_back({1'b1, CsrTimeoutRdata});
    waitPulse("timeout", p0, 200);
    check("timeout_cycles", 64'(pulseCycle - frameDoneCycle), 64'd17);
    csr = '0;
    repeat (3) step();
`else
    for (int n = 0; n < 1010; n++) step();
    check("no_timeout_pulse", 64'(pulses), 64'(p0));
    check("no_timeout_frame_sent", 64'(reqByteQ.size()), 64'd0);
    check("no_timeout_still_waiting", 64'(bcOut.ready), 64'd1);
    csr = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
`endif
    check("fb_queue_empty", 64'(fbExpQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oclib_csr_to_bc.md
Name: oclib_csr_to_bc

Overview:
- CSR initiator-side bridge: accepts one CSR request from a local master and serializes it as bytes onto an 8-bit bidirectional byte channel (BC).
- Deserializes the returned response bytes and presents them as CSR feedback.
- Is the far end of a remote BC-to-CSR responder; lets a control plane reach CSR space across a BC link or chain.

Parameters:
- BcType, oclib_pkg::bc_8b_bidi_s, BC bidi struct. Fields: data[7:0], valid, ready (ready = backpressure for the opposite stream).
- CsrType, oclib_pkg::csr_32_s, CSR request struct. Fields: read, write, address[31:0], wdata[31:0]; 66 bits.
- CsrFbType, oclib_pkg::csr_32_fb_s, CSR feedback struct. Fields: rdata[31:0], ready, error; 34 bits.
- TimeoutCycles, 1024, response timeout in cycles. Used only with the optional feature.

Ports:
- clock  input  1  sole clock.
- reset  input  1  asynchronous, active-high reset; all flops clear immediately on assertion.
- csr  input  $bits(CsrType)  request from local CSR master.
- csrFb  output  $bits(CsrFbType)  feedback to local CSR master.
- bcOut  output  $bits(BcType)  request bytes toward remote; ready field = our acceptance of bcIn bytes.
- bcIn  input  $bits(BcType)  response bytes from remote; ready field = remote acceptance of bcOut bytes.

Behaviour:
- Reset values: csrFb all zero; bcOut.valid=0; bcOut.data=0; bcOut.ready=1; FSM=Idle; byte counters=0.
- Sizes: ReqBytes = ceil($bits(CsrType)/8) = 9. RespBytes = ceil($bits(CsrFbType)/8) = 5.
- Packing: request packed LSB byte first; pad bits in the last byte are 0. Response unpacked LSB byte first; pad bits ignored.
- Output byte handshake: a byte transfers on a cycle with bcOut.valid && bcIn.ready. data and valid hold stable until transfer.
- Input byte handshake: a byte transfers on a cycle with bcIn.valid && bcOut.ready. bcOut.ready=1 in every state except Ack.
- FSM:
  - Idle: if read^write, capture csr into a shift register and go to SendReq. If read&&write, go to Ack with error=1, rdata=0, and send nothing. Bytes received in Idle are accepted and discarded.
  - SendReq: drive the byte at the counter; advance on transfer. After byte ReqBytes-1 transfers, clear the counter and go to WaitResp.
  - WaitResp: shift each received byte in. After RespBytes bytes, go to Ack.
  - Ack: drive csrFb for exactly one cycle with ready=1, rdata and error from the response; go to Hold.
  - Hold: csrFb.ready=0; rdata and error retained. Go to Idle when read=0 and write=0. This prevents a held request from reissuing.
- Latency, zero BC backpressure: request capture→first byte valid = 1 cycle; last response byte→csrFb.ready = 1 cycle.
- The request is sampled only in Idle. Changes to csr after capture are ignored.
- Responses must be byte-aligned to requests; only one transaction is outstanding.
- Reset mid-transaction: immediate return to Idle with reset values. A partial frame already sent is the remote's responsibility; any late bytes are discarded in Idle.

Optional Feature:
- Macro: OC_CSR_TO_BC_TIMEOUT_EN.
- Enabled:
  - A 32-bit counter clears on entry to WaitResp and increments each WaitResp cycle without an input transfer.
  - On reaching TimeoutCycles, go to Ack with error=1 and rdata=32'hDEAD_DEAD.
  - Late response bytes are then discarded in Idle.
- Disabled: no counter; WaitResp can hang indefinitely; TimeoutCycles is unused.

Decomposition:
- Package oclib_pkg already holds bc_8b_bidi_s, csr_32_s and csr_32_fb_s. Add constants CsrToBcTimeoutDefault=1024 and CsrTimeoutRdata=32'hDEAD_DEAD.
- Natural sub-module: oclib_words_to_bc_bidi, a generic word serializer (WordOutWidth) plus deserializer (WordInWidth) with valid/ready word ports.
- The top module keeps the CSR FSM, Hold logic and timeout.

Test Plan:
- Write: address=32'h0000_0010, wdata=32'hA5A5_1234, no backpressure → bcOut bytes 01? Check the exact packed LSB-first sequence against a golden pack of the struct (9 bytes, last byte pad=0). Return response rdata=0, error=0 → one-cycle csrFb.ready, error=0.
- Read with a random 50% low duty on bcIn.ready → data stable while stalled. Remote returns rdata=32'hCAFE_F00D → csrFb.rdata=32'hCAFE_F00D, ready pulses once.
- Read and write both high → nothing on bcOut; ready pulse with error=1 after 1 cycle.
- Master holds read=1 for 20 cycles after ready → exactly one request frame sent. Deassert then reassert → second frame sent.
- Assert reset after 4 request bytes → bcOut.valid=0 and csrFb=0 in the same cycle. 3 stray bytes afterwards are discarded. Next read completes normally.
- Timeout build with TimeoutCycles=16, no response → ready with error=1 and rdata=32'hDEAD_DEAD at 16 cycles after entering WaitResp. Without the macro, no pulse within 1000 cycles.
